// File: rtl/serial_frame_reader_pkg.sv
// Shared definitions for the serial frame reader: state encoding, width helpers
// and the default word size of the attached serial read buffer.
package serial_frame_reader_pkg;

    localparam int DEFAULT_BUF_SIZE = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_BUSY     = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_WAIT_END = 3'd5
    } state_t;

    function automatic int cnt_width(input int buf_size);
        return $clog2(buf_size + 1);
    endfunction

    function automatic int wrd_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/serial_frame_reader_edge.sv
// Rising-edge detector on an already synchronised level; the pulse is
// combinational so it lines up with the edge that samples the new level.
module serial_frame_reader_edge
    import serial_frame_reader_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/serial_frame_reader.sv
// Sequencer that walks one serial read buffer through a multi-word frame,
// delivering each word with a strobe and aborting if the frame ends early.
module serial_frame_reader
    import serial_frame_reader_pkg::*;
#(
    parameter int BUF_SIZE  = DEFAULT_BUF_SIZE,
    parameter int MAX_WORDS = 4,
    parameter int CNT_W     = cnt_width(BUF_SIZE),
    parameter int WRD_W     = wrd_width(MAX_WORDS)
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                frame_active,
    input  logic [WRD_W-1:0]    cfg_words,
    input  logic [CNT_W-1:0]    cfg_last_bits,
    output logic                buf_start,
    output logic [CNT_W-1:0]    buf_read_count,
    output logic                buf_rst,
    input  logic [BUF_SIZE-1:0] buf_data,
    input  logic                buf_done,
    output logic [BUF_SIZE-1:0] word_data,
    output logic [WRD_W-1:0]    word_idx,
    output logic                word_valid,
    output logic                frame_done,
    output logic                frame_abort,
    output logic                busy
);

    localparam logic [WRD_W-1:0] MAX_WORDS_W = WRD_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(BUF_SIZE);

    function automatic logic [WRD_W-1:0] clamp_words(input logic [WRD_W-1:0] w);
        if (w == '0) begin
            return WRD_W'(1);
        end else if (w > MAX_WORDS_W) begin
            return MAX_WORDS_W;
        end else begin
            return w;
        end
    endfunction

    function automatic logic [CNT_W-1:0] clamp_last(input logic [CNT_W-1:0] b);
        if (b == '0 || b > FULL_COUNT) begin
            return FULL_COUNT;
        end else begin
            return b;
        end
    endfunction

    state_t              state_q, state_d;
    logic [WRD_W-1:0]    words_q;
    logic [CNT_W-1:0]    last_bits_q;
    logic [WRD_W-1:0]    idx_q;
    logic [WRD_W:0]      idx_next;
    logic                last_word;
    logic                abort_q, abort_d;
    logic [BUF_SIZE-1:0] word_data_q;
    logic [WRD_W-1:0]    word_idx_q;
    logic                rise;
    logic                in_read;
    logic                latch_cfg, clear_idx, advance, capture;

    serial_frame_reader_edge u_edge (
        .clk   (sys_clk),
        .rst   (rst),
        .level (frame_active),
        .rise  (rise)
    );

    assign idx_next  = {1'b0, idx_q} + (WRD_W+1)'(1);
    assign last_word = (idx_next >= {1'b0, words_q});
    assign in_read   = (state_q == ST_START) || (state_q == ST_SETTLE) ||
                       (state_q == ST_BUSY)  || (state_q == ST_CAPTURE);

    always_comb begin
        state_d        = state_q;
        abort_d        = 1'b0;
        latch_cfg      = 1'b0;
        clear_idx      = 1'b0;
        advance        = 1'b0;
        capture        = 1'b0;
        word_valid     = 1'b0;
        frame_done     = 1'b0;
        buf_start      = (state_q == ST_START);
        busy           = (state_q != ST_IDLE);
        buf_read_count = '0;

        if (in_read) begin
            buf_read_count = last_word ? last_bits_q : FULL_COUNT;
        end

        // Losing the frame level while a word is in flight always wins,
        // including over a simultaneous buf_done or a pending capture strobe.
        if (in_read && !frame_active) begin
            abort_d   = 1'b1;
            clear_idx = 1'b1;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise && enable) begin
                        latch_cfg = 1'b1;
                        clear_idx = 1'b1;
                        state_d   = ST_START;
                    end
                end
                ST_START:  state_d = ST_SETTLE;
                // The buffer still shows done from the previous word here.
                ST_SETTLE: state_d = ST_BUSY;
                ST_BUSY: begin
                    if (buf_done) begin
                        capture = 1'b1;
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    word_valid = 1'b1;
                    advance    = 1'b1;
                    if (last_word) begin
                        frame_done = 1'b1;
                        state_d    = ST_WAIT_END;
                    end else begin
                        state_d = ST_START;
                    end
                end
                ST_WAIT_END: begin
                    if (!frame_active) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            abort_q     <= 1'b0;
            words_q     <= '0;
            last_bits_q <= '0;
            idx_q       <= '0;
            word_data_q <= '0;
            word_idx_q  <= '0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
            if (latch_cfg) begin
                words_q     <= clamp_words(cfg_words);
                last_bits_q <= clamp_last(cfg_last_bits);
            end
            if (clear_idx) begin
                idx_q <= '0;
            end else if (advance) begin
                idx_q <= idx_next[WRD_W-1:0];
            end
            if (capture) begin
                word_data_q <= buf_data;
                word_idx_q  <= idx_q;
            end
        end
    end

    assign buf_rst     = abort_q;
    assign frame_abort = abort_q;
    assign word_data   = word_data_q;
    assign word_idx    = word_idx_q;

endmodule

// File: tb/tb_serial_frame_reader.sv
// Bench for serial_frame_reader: a behavioural serial buffer, a frame-level
// reference model checked every cycle, and directed plus randomized frames.
module tb_serial_frame_reader;

    localparam int BUF_SIZE  = 8;
    localparam int MAX_WORDS = 4;
    localparam int CNT_W     = 4;
    localparam int WRD_W     = 3;

    logic                sys_clk;
    logic                rst;
    logic                enable;
    logic                frame_active;
    logic [WRD_W-1:0]    cfg_words;
    logic [CNT_W-1:0]    cfg_last_bits;
    logic                buf_start;
    logic [CNT_W-1:0]    buf_read_count;
    logic                buf_rst;
    logic [BUF_SIZE-1:0] buf_data;
    logic                buf_done;
    logic [BUF_SIZE-1:0] word_data;
    logic [WRD_W-1:0]    word_idx;
    logic                word_valid;
    logic                frame_done;
    logic                frame_abort;
    logic                busy;

    serial_frame_reader #(.BUF_SIZE(BUF_SIZE), .MAX_WORDS(MAX_WORDS)) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .enable         (enable),
        .frame_active   (frame_active),
        .cfg_words      (cfg_words),
        .cfg_last_bits  (cfg_last_bits),
        .buf_start      (buf_start),
        .buf_read_count (buf_read_count),
        .buf_rst        (buf_rst),
        .buf_data       (buf_data),
        .buf_done       (buf_done),
        .word_data      (word_data),
        .word_idx       (word_idx),
        .word_valid     (word_valid),
        .frame_done     (frame_done),
        .frame_abort    (frame_abort),
        .busy           (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial buffer stand-in: done stays high (stale) until two cycles after
    // the next start, then rises again after count * bit_per cycles.
    int        bit_per = 4;
    int        buf_ptr = 0;
    int        clr_dly = 0;
    int        remaining = 0;
    int        total = 0;
    logic [7:0] pend;
    logic [7:0] tx [4];

    initial begin
        int m;
        buf_done = 1'b0;
        buf_data = 8'h00;
        pend     = 8'h00;
        forever begin
            @(posedge sys_clk);
            #1;
            if (!rst) begin
                buf_done = 1'b0; clr_dly = 0; remaining = 0; total = 0;
            end else if (buf_rst) begin
                buf_done = 1'b0; clr_dly = 0; remaining = 0;
            end else if (buf_start) begin
                m         = (1 << int'(buf_read_count)) - 1;
                pend      = tx[buf_ptr % 4] & m[7:0];
                total     = int'(buf_read_count) * bit_per;
                remaining = total;
                clr_dly   = 2;
                buf_ptr++;
            end else if (clr_dly > 0) begin
                clr_dly--;
                if (clr_dly == 0) buf_done = 1'b0;
            end else if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    buf_done = 1'b1;
                    buf_data = pend;
                end
            end
        end
    end

    // Frame-level reference model and per-cycle compare.
    int   n_start = 0, n_wv = 0, n_fd = 0, n_abort = 0, n_rst = 0;
    int   count_log [8];
    int   data_log  [8];
    int   idx_log   [8];
    bit   p_fa, p2_fa, p_en, p_inf, p_complete, p_fresh, p_wv, p_fd;
    int   p_cw, p_clb, p_bdata;
    int   m_words, m_last, word_n, since;
    bit   inf, complete, done_seen;

    initial begin
        bit rise_q, e_abort, e_start, e_wv, e_fd, fresh;
        int exp_cnt;
        p_fa = 0; p2_fa = 0; p_en = 0; p_inf = 0; p_complete = 0; p_fresh = 0;
        p_wv = 0; p_fd = 0; p_cw = 0; p_clb = 0; p_bdata = 0;
        m_words = 1; m_last = 8; word_n = 0; since = 0; inf = 0; complete = 0; done_seen = 0;
        forever begin
            @(negedge sys_clk);
            if (!rst) begin
                check("reset_ctrl", int'({buf_start, word_valid, frame_done, frame_abort, buf_rst, busy}), 0);
                p_fa = 0; p2_fa = 0; p_en = 0; p_inf = 0; p_complete = 0; p_fresh = 0;
                p_wv = 0; p_fd = 0; inf = 0; complete = 0; done_seen = 0; since = 0;
            end else begin
                rise_q = p_fa && !p2_fa && !p_inf && p_en;
                if (rise_q) begin
                    m_words  = (p_cw == 0) ? 1 : ((p_cw > MAX_WORDS) ? MAX_WORDS : p_cw);
                    m_last   = (p_clb == 0 || p_clb > BUF_SIZE) ? BUF_SIZE : p_clb;
                    word_n   = 0;
                    complete = 0;
                end
                e_abort = p_inf && !p_fa && !p_complete;
                inf     = rise_q || (p_inf && p_fa);
                e_start = rise_q || (p_wv && !p_fd);
                e_wv    = p_fresh && p_fa && frame_active;
                e_fd    = e_wv && (word_n == m_words - 1);
                check("ctrl{start,wv,fd,abort,rst,busy}",
                      int'({buf_start, word_valid, frame_done, frame_abort, buf_rst, busy}),
                      int'({e_start, e_wv, e_fd, e_abort, e_abort, inf}));
                if (inf && !complete) begin
                    exp_cnt = (word_n < m_words - 1) ? BUF_SIZE : m_last;
                    check("buf_read_count", int'(buf_read_count), exp_cnt);
                end
                if (e_wv && word_valid) begin
                    check("word_data", int'(word_data), p_bdata);
                    check("word_idx", int'(word_idx), word_n);
                end
                if (buf_start) begin count_log[n_start % 8] = int'(buf_read_count); n_start++; end
                if (word_valid) begin
                    data_log[n_wv % 8] = int'(word_data);
                    idx_log[n_wv % 8]  = int'(word_idx);
                    n_wv++;
                end
                if (frame_done)  n_fd++;
                if (frame_abort) n_abort++;
                if (buf_rst)     n_rst++;

                if (e_start) begin since = 0; done_seen = 0; end
                else since++;
                fresh = inf && !complete && since >= 2 && buf_done && !done_seen;
                if (fresh) done_seen = 1;
                if (e_fd) complete = 1;
                if (e_wv) word_n++;

                p2_fa = p_fa; p_fa = frame_active; p_en = enable;
                p_inf = inf; p_complete = complete; p_fresh = fresh;
                p_wv = e_wv; p_fd = e_fd;
                p_cw = int'(cfg_words); p_clb = int'(cfg_last_bits); p_bdata = int'(buf_data);
            end
        end
    end

    task automatic run_frame(input int w, input int lb, input bit en0,
                             input int aw, input int ab, input bit drop);
        int s0, f0, a0, g;
        bit stop;
        s0 = n_start; f0 = n_fd; a0 = n_abort;
        @(posedge sys_clk); #2;
        buf_ptr       = 0;
        enable        = en0;
        cfg_words     = 3'(w);
        cfg_last_bits = 4'(lb);
        frame_active  = 1'b1;
        g = 0; stop = 0;
        while (!stop) begin
            @(posedge sys_clk); #2;
            g++;
            if (drop && g == 3) enable = 1'b0;
            if (n_fd != f0 || n_abort != a0) begin
                stop = 1;
            end else if (g >= 12 && n_start == s0) begin
                stop = 1;
            end else if (aw >= 0 && buf_ptr == aw + 1 && clr_dly == 0 &&
                         (total - remaining) >= ab * bit_per) begin
                frame_active = 1'b0;
                stop = 1;
            end else if (g >= 3000) begin
                check("frame_timeout_cycles", g, 0);
                stop = 1;
            end
        end
        repeat ($urandom_range(1, 3)) @(posedge sys_clk);
        #2;
        frame_active = 1'b0;
        enable       = 1'b1;
        repeat (4) @(posedge sys_clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t, expected end earlier", $time);
        $fatal(1);
    end

    initial begin
        int s0, w0, f0, a0, r0;
        rst = 1'b1; enable = 1'b0; frame_active = 1'b0;
        cfg_words = '0; cfg_last_bits = '0;
        tx[0] = 8'h00; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h00;
        #1 rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_outputs", int'({buf_start, buf_read_count, buf_rst, word_data, word_idx,
                                     word_valid, frame_done, frame_abort, busy}), 0);
        @(posedge sys_clk); #3 rst = 1'b1;
        enable = 1'b1;
        repeat (2) @(posedge sys_clk);

        // Single full word
        tx[0] = 8'h3A;
        s0 = n_start; w0 = n_wv; f0 = n_fd;
        run_frame(1, 8, 1'b1, -1, 0, 1'b0);
        check("t1_starts", n_start - s0, 1);
        check("t1_count", count_log[s0 % 8], 8);
        check("t1_data", data_log[w0 % 8], 8'h3A);
        check("t1_idx", idx_log[w0 % 8], 0);
        check("t1_frame_done", n_fd - f0, 1);

        // Three-word frame with a 6-bit tail
        tx[0] = 8'hA5; tx[1] = 8'h5A; tx[2] = 8'hEA;
        s0 = n_start; w0 = n_wv; f0 = n_fd;
        run_frame(3, 6, 1'b1, -1, 0, 1'b0);
        check("t3_count0", count_log[s0 % 8], 8);
        check("t3_count1", count_log[(s0 + 1) % 8], 8);
        check("t3_count2", count_log[(s0 + 2) % 8], 6);
        check("t3_data0", data_log[w0 % 8], 8'hA5);
        check("t3_data1", data_log[(w0 + 1) % 8], 8'h5A);
        check("t3_data2", data_log[(w0 + 2) % 8], 8'h2A);
        check("t3_idx2", idx_log[(w0 + 2) % 8], 2);
        check("t3_frame_done", n_fd - f0, 1);

        // Early frame end 3 bits into word 1
        tx[0] = 8'hC3; tx[1] = 8'h99;
        w0 = n_wv; f0 = n_fd; a0 = n_abort; r0 = n_rst;
        run_frame(2, 8, 1'b1, 1, 3, 1'b0);
        check("abort_strobes", n_abort - a0, 1);
        check("abort_buf_rst", n_rst - r0, 1);
        check("abort_words", n_wv - w0, 1);
        check("abort_word0", data_log[w0 % 8], 8'hC3);
        check("abort_no_done", n_fd - f0, 0);
        check("abort_busy", int'(busy), 0);

        // Gating
        s0 = n_start;
        run_frame(2, 8, 1'b0, -1, 0, 1'b0);
        check("gated_no_start", n_start - s0, 0);
        w0 = n_wv; f0 = n_fd;
        run_frame(3, 8, 1'b1, -1, 0, 1'b1);
        check("en_drop_words", n_wv - w0, 3);
        check("en_drop_done", n_fd - f0, 1);

        // Clamping
        w0 = n_wv;
        run_frame(0, 8, 1'b1, -1, 0, 1'b0);
        check("clamp_words0", n_wv - w0, 1);
        s0 = n_start;
        run_frame(1, 0, 1'b1, -1, 0, 1'b0);
        check("clamp_last0", count_log[s0 % 8], 8);
        s0 = n_start; w0 = n_wv;
        run_frame(7, 12, 1'b1, -1, 0, 1'b0);
        check("clamp_words7", n_wv - w0, 4);
        check("clamp_last12", count_log[(s0 + 3) % 8], 8);

        // Asynchronous reset while waiting on the buffer
        begin
            int g;
            @(posedge sys_clk); #2;
            buf_ptr = 0; cfg_words = 3'd2; cfg_last_bits = 4'd8; frame_active = 1'b1;
            g = 0;
            while (!(buf_ptr == 1 && clr_dly == 0 && remaining > 0 && remaining < total) && g < 500) begin
                @(posedge sys_clk); #2;
                g++;
            end
            check("rst_reach_busy_timeout", int'(g >= 500), 0);
            rst = 1'b0;
            #1;
            check("async_rst_outputs", int'({buf_start, buf_read_count, buf_rst, word_data, word_idx,
                                             word_valid, frame_done, frame_abort, busy}), 0);
            frame_active = 1'b0;
            @(posedge sys_clk); #3 rst = 1'b1;
            repeat (2) @(posedge sys_clk);
        end
        tx[0] = 8'h77;
        w0 = n_wv;
        run_frame(1, 8, 1'b1, -1, 0, 1'b0);
        check("post_rst_words", n_wv - w0, 1);
        check("post_rst_data", data_log[w0 % 8], 8'h77);
        check("post_rst_idx", idx_log[w0 % 8], 0);

        // Randomized frames
        repeat (60) begin
            int w, lb, aw, ab;
            bit en0, drop;
            for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
            bit_per = $urandom_range(4, 6);
            w       = $urandom_range(0, 7);
            lb      = $urandom_range(0, 15);
            en0     = ($urandom_range(0, 9) != 0);
            drop    = ($urandom_range(0, 4) == 0);
            aw      = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            ab      = $urandom_range(0, 8);
            run_frame(w, lb, en0, aw, ab, drop);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_frame_reader.md
# serial_frame_reader

Sequencer that drives one `SerialReadBuffer` to capture a multi-word frame from a serial input line. On the start of a framing interval (chip-select / line-active level, already synchronised to `sys_clk`), it issues successive read commands: full `BUF_SIZE` words, then a final word of configurable length. It delivers each word with a one-cycle strobe, signals frame completion, and aborts cleanly (buffer reset plus abort strobe) if the frame ends early. It sits between the line synchroniser/edge detector and the MITM packet logic.

## Interface
- `BUF_SIZE`, 8: bits per word; must match the attached buffer.
- `MAX_WORDS`, 4: maximum words per frame; must be ≥1.
- `CNT_W`, `$clog2(BUF_SIZE+1)`: width of the read-count field (derived, not overridden).
- `WRD_W`, `$clog2(MAX_WORDS+1)`: width of the word-count field (derived).

Ports:
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, new frames are ignored; a frame in progress completes.
- `frame_active`  in  1  synchronised frame level; high = frame in progress.
- `cfg_words`  in  WRD_W  words per frame, 1..MAX_WORDS.
- `cfg_last_bits`  in  CNT_W  bit length of the final word, 1..BUF_SIZE.
- `buf_start`  out  1  one-cycle start pulse to the buffer.
- `buf_read_count`  out  CNT_W  bit count for the current word; stable from `buf_start` until `buf_done`.
- `buf_rst`  out  1  one-cycle reset pulse to the buffer (active-high, as the buffer expects).
- `buf_data`  in  BUF_SIZE  buffer parallel output.
- `buf_done`  in  1  buffer done level.
- `word_data`  out  BUF_SIZE  captured word; held until the next capture.
- `word_idx`  out  WRD_W  index of `word_data`, counting from 0.
- `word_valid`  out  1  one-cycle strobe: `word_data` / `word_idx` are new.
- `frame_done`  out  1  one-cycle strobe: all `cfg_words` words captured.
- `frame_abort`  out  1  one-cycle strobe: frame ended before completion.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Reset.** All outputs are 0; state is IDLE; internal counters are 0.
- **Latching.** On a `frame_active` rising edge while in IDLE with `enable`=1, latch `cfg_words` and `cfg_last_bits`. Out-of-range values are clamped:
  - `cfg_words` = 0 is treated as 1; values > MAX_WORDS are treated as MAX_WORDS.
  - `cfg_last_bits` = 0 or > BUF_SIZE is treated as BUF_SIZE.
- **States:**
  - **IDLE** → START on the qualified rising edge.
  - **START:** `buf_start`=1. `buf_read_count` = BUF_SIZE for word index < words−1; otherwise `cfg_last_bits`. → SETTLE.
  - **SETTLE:** one cycle, so that the stale `buf_done` is ignored. → BUSY.
  - **BUSY:** wait for `buf_done`=1. → CAPTURE.
  - **CAPTURE:** register `word_data` ← `buf_data`, `word_idx` ← index, `word_valid`=1, then increment the index.
    - If index+1 < words → START.
    - Otherwise `frame_done`=1 → WAIT_END.
  - **WAIT_END:** wait for `frame_active`=0 → IDLE. Extra bits on the line are ignored (no overrun error).
- **Abort.** If `frame_active`=0 in START, SETTLE, BUSY or CAPTURE:
  - Pulse `buf_rst` and `frame_abort`; go to IDLE; clear the index.
  - In CAPTURE the abort wins: no `word_valid`.
- **Simultaneous events.** If `buf_done` and `frame_active` fall in the same BUSY cycle, the abort wins and the partial word is discarded.
- **Data alignment.** Short last words are passed through exactly as the buffer presents them; the controller does no shifting.
- **Mid-operation reset.** Asynchronous reset returns to IDLE immediately. `buf_rst` is not pulsed, because the buffer shares the system reset.

## Timing
- `frame_active` rise sampled at edge N → `buf_start` high in cycle N+1.
- `buf_done` sampled high at edge K → `word_valid` in cycle K+1; the next `buf_start` follows in cycle K+2.
- `frame_done` coincides with the last `word_valid`.
- Abort strobes are issued in the cycle after `frame_active` is sampled low.
- Words are back-to-back with a 3-cycle controller overhead. The serial bit period must be ≥4 `sys_clk` cycles, so that no bit is lost between words.

## Structure
- Shared package holds:
  - the state encoding (IDLE, START, SETTLE, BUSY, CAPTURE, WAIT_END; 3-bit);
  - the CNT_W / WRD_W width functions;
  - the default BUF_SIZE.
- One sub-module: the existing `EdgeDetector` (rising) on `frame_active` for start qualification. The falling edge is not needed, because abort is level-based.

## Test plan
- **Single full word.** `cfg_words`=1, `cfg_last_bits`=8, send 0x3A → one `buf_start` with count 8; `word_valid` with `word_data`=0x3A, idx 0; `frame_done` in the same cycle.
- **Three-word frame.** `cfg_last_bits`=6; send 0xA5, 0x5A, 6'o52 → counts 8, 8, 6; idx 0, 1, 2; `frame_done` with the third word only.
- **Early frame end.** `frame_active` drops after 3 bits of word 1 of a 2-word frame → `buf_rst` and `frame_abort` pulse once; word 0 is still delivered; no word-1 `word_valid`; `busy`=0.
- **Gating.** `enable`=0 at a `frame_active` rise → no `buf_start`. `enable` deasserted mid-frame → the frame completes normally.
- **Clamping.** `cfg_words`=0 → one word is read. `cfg_last_bits`=0 → count 8 is used.
- **Async reset mid-BUSY.** All outputs go to 0 immediately; the next frame reads correctly from idx 0.
